// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Single-issue ALU execution unit with a valid/ready handshake on both
//   sides. Single-cycle ops (ADD/SUB/AND/OR/SLT/NOR and illegal requests)
//   produce a result one cycle after accept. MUL runs an iterative
//   shift-add multiply, one bit per cycle, for WIDTH cycles.
//
//   Parameters
//     WIDTH   operand/result width (4..64)
//     MUL_EN  nonzero enables MUL (funct 011000); zero makes it illegal
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     in_valid/in_ready   request handshake
//     alu_op, funct, a, b request: decoder class, R-type funct, operands
//     out_valid/out_ready response handshake
//     result, zero        registered result and its zero flag
//     alu_ctrl, illegal   decoded control code of the held result, and
//                         whether the request was illegal
//     busy                high while the multiply is iterating
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [3:0]       alu_ctrl,
  output logic             illegal,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_MUL = 4'b1000;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_ILL = 4'b1111;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [3:0]       dec_ctrl;
  logic [WIDTH-1:0] op_res;
  logic             accept;

  // Every (alu_op, funct) pair maps to a defined code; unknown ones are illegal.
  function automatic logic [3:0] decode(input logic [1:0] op, input logic [5:0] fn);
    logic [3:0] c;
    c = CTRL_ILL;
    case (op)
      2'b00: c = CTRL_ADD;
      2'b01: c = CTRL_SUB;
      2'b10: begin
        case (fn)
          6'b100000: c = CTRL_ADD;
          6'b100010: c = CTRL_SUB;
          6'b100100: c = CTRL_AND;
          6'b100101: c = CTRL_OR;
          6'b101010: c = CTRL_SLT;
          6'b100111: c = CTRL_NOR;
          6'b011000: c = (MUL_EN != 0) ? CTRL_MUL : CTRL_ILL;
          default:   c = CTRL_ILL;
        endcase
      end
      default: c = CTRL_ILL;
    endcase
    return c;
  endfunction

  // Single-cycle datapath; MUL and illegal codes yield zero here.
  function automatic logic [WIDTH-1:0] compute(input logic [3:0] ctrl,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    r = '0;
    case (ctrl)
      CTRL_ADD: r = x + y;
      CTRL_SUB: r = x - y;
      CTRL_AND: r = x & y;
      CTRL_OR:  r = x | y;
      CTRL_NOR: r = ~(x | y);
      CTRL_SLT: r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign in_ready = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_ctrl = decode(alu_op, funct);
    op_res   = compute(dec_ctrl, a, b);
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  // Multiply working registers carry no reset: a reset abandons any
  // partial product and they are reloaded on the next MUL accept.
  always_ff @(posedge clk) begin
    if (accept && (dec_ctrl == CTRL_MUL)) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (state == ST_MUL) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      alu_ctrl  <= 4'b0000;
      illegal   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            if (dec_ctrl == CTRL_MUL) begin
              state     <= ST_MUL;
              busy      <= 1'b1;
              out_valid <= 1'b0;
              cnt       <= CNT_W'(WIDTH);
            end else begin
              state     <= ST_HOLD;
              out_valid <= 1'b1;
              result    <= op_res;
              zero      <= (op_res == '0);
              alu_ctrl  <= dec_ctrl;
              illegal   <= (dec_ctrl == CTRL_ILL);
            end
          end else if ((state == ST_HOLD) && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        ST_MUL: begin
          cnt <= cnt - CNT_W'(1);
          // Last shift-add step: publish the completed low product.
          if (cnt == CNT_W'(1)) begin
            state     <= ST_HOLD;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            result    <= acc_next;
            zero      <= (acc_next == '0);
            alu_ctrl  <= CTRL_MUL;
            illegal   <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
